// File: rtl/demux_chan_counter.sv
// Four-channel event counter for the 1-to-4 demux outputs: synchronise, edge-detect, count with
// saturation, and stream a snapshot of all four counts over a valid/ready handshake.
module demux_chan_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       y_in,
   input  logic             clear,
   input  logic             rd_req,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [1:0]       out_chan,
   output logic [CNT_W-1:0] out_count,
   output logic             busy,
   output logic             rd_done
);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   localparam logic [CNT_W-1:0] CntMax = '1;

   state_e           state_q;
   logic [1:0]       idx_q;
   logic [3:0]       s1_q, s2_q, h_q;
   logic [3:0]       rise;
   logic [CNT_W-1:0] cnt_q    [4];
   logic [CNT_W-1:0] shadow_q [4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
         h_q  <= '0;
      end else begin
         s1_q <= y_in;
         s2_q <= s1_q;
         h_q  <= s2_q;
      end
   end

   assign rise = s2_q & ~h_q;

   // clear wins over a coincident increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (clear) begin
               cnt_q[k] <= '0;
            end else if (rise[k] && (cnt_q[k] != CntMax)) begin
               cnt_q[k] <= cnt_q[k] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         for (int k = 0; k < 4; k++) shadow_q[k] <= '0;
         out_valid <= 1'b0;
         out_chan  <= '0;
         out_count <= '0;
         busy      <= 1'b0;
         rd_done   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rd_req) begin
                  // snapshot sees pre-increment / pre-clear live values
                  for (int k = 0; k < 4; k++) shadow_q[k] <= cnt_q[k];
                  idx_q     <= '0;
                  out_valid <= 1'b1;
                  out_chan  <= '0;
                  out_count <= cnt_q[0];
                  busy      <= 1'b1;
                  state_q   <= StSend;
               end
            end
            StSend: begin
               if (out_ready) begin
                  if (idx_q == 2'd3) begin
                     out_valid <= 1'b0;
                     out_chan  <= '0;
                     out_count <= '0;
                     rd_done   <= 1'b1;
                     state_q   <= StDone;
                  end else begin
                     idx_q     <= idx_q + 2'd1;
                     out_chan  <= idx_q + 2'd1;
                     out_count <= shadow_q[idx_q + 2'd1];
                  end
               end
            end
            StDone: begin
               rd_done <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_demux_chan_counter.sv
// Bench for demux_chan_counter: behavioural model checked every cycle, plus directed readouts
// with literal expectations and a randomized phase.
module tb_demux_chan_counter;

   localparam int unsigned CNT_W = 8;
   localparam int MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic [3:0]       y_in;
   logic             clear;
   logic             rd_req;
   logic             out_ready;
   logic             out_valid;
   logic [1:0]       out_chan;
   logic [CNT_W-1:0] out_count;
   logic             busy;
   logic             rd_done;

   int errs   = 0;
   int checks = 0;

   demux_chan_counter #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .y_in      (y_in),
      .clear     (clear),
      .rd_req    (rd_req),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_chan  (out_chan),
      .out_count (out_count),
      .busy      (busy),
      .rd_done   (rd_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: counts are rising edges of the sampled y_in waveform, seen two edges late;
   // a readout is a queue of four (chan, count) words followed by one done cycle.
   int       m_cnt [4];
   bit [3:0] samp0, samp1, samp2;
   int       q_chan [$];
   int       q_cnt  [$];
   bit       m_done;

   initial begin
      int ev, ec, en, eb, ed;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      samp0 = '0; samp1 = '0; samp2 = '0; m_done = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            samp0 = '0; samp1 = '0; samp2 = '0;
            q_chan.delete(); q_cnt.delete(); m_done = 0;
         end else begin
            if (q_chan.size() > 0) begin
               if (out_ready) begin
                  void'(q_chan.pop_front());
                  void'(q_cnt.pop_front());
                  if (q_chan.size() == 0) m_done = 1;
               end
            end else if (m_done) begin
               m_done = 0;
            end else if (rd_req) begin
               for (int k = 0; k < 4; k++) begin
                  q_chan.push_back(k);
                  q_cnt.push_back(m_cnt[k]);
               end
            end
            for (int k = 0; k < 4; k++) begin
               if (clear) m_cnt[k] = 0;
               else if (samp1[k] && !samp2[k] && m_cnt[k] < MAX) m_cnt[k]++;
            end
            samp2 = samp1; samp1 = samp0; samp0 = y_in;
         end
         #1;
         if (q_chan.size() > 0) begin
            ev = 1; ec = q_chan[0]; en = q_cnt[0]; eb = 1; ed = 0;
         end else if (m_done) begin
            ev = 0; ec = 0; en = 0; eb = 1; ed = 1;
         end else begin
            ev = 0; ec = 0; en = 0; eb = 0; ed = 0;
         end
         chk("m_valid", int'(out_valid), ev);
         chk("m_chan",  int'(out_chan),  ec);
         chk("m_count", int'(out_count), en);
         chk("m_busy",  int'(busy),      eb);
         chk("m_done",  int'(rd_done),   ed);
      end
   end

   task automatic pulse(input int ch);
      y_in[ch] = 1'b1;
      repeat (2) @(negedge clk);
      y_in[ch] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   // Called at a negedge with the FSM idle; ready held high throughout.
   task automatic readout(input int e0, input int e1, input int e2, input int e3);
      int exp [4];
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
      rd_req    = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("rd_valid", int'(out_valid), 1);
         chk("rd_chan",  int'(out_chan),  i);
         chk("rd_count", int'(out_count), exp[i]);
         @(negedge clk);
      end
      chk("rd_done_pulse", int'(rd_done), 1);
      chk("rd_done_valid", int'(out_valid), 0);
      @(negedge clk);
      chk("rd_done_clr", int'(rd_done), 0);
      chk("rd_idle_busy", int'(busy), 0);
   endtask

   initial begin
      rst_n = 1'b0; y_in = '0; clear = 1'b0; rd_req = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_busy",  int'(busy),      0);
      chk("rst_count", int'(out_count), 0);
      rst_n = 1'b1;
      @(negedge clk);
      readout(0, 0, 0, 0);

      // Demux sweep: I toggles every 10 clk, S steps every 100 clk
      do_clear();
      for (int c = 0; c < 400; c++) begin
         y_in = ((c / 10) % 2 == 1) ? 4'(1 << (c / 100)) : 4'b0000;
         @(negedge clk);
      end
      y_in = '0;
      repeat (4) @(negedge clk);
      readout(5, 5, 5, 5);

      // Saturation on channel 2
      do_clear();
      for (int p = 0; p < 300; p++) pulse(2);
      repeat (2) @(negedge clk);
      readout(0, 0, MAX, 0);
      pulse(2);
      repeat (2) @(negedge clk);
      readout(0, 0, MAX, 0);

      // Backpressure on the chan 1 word, with an ignored rd_req
      rd_req = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
      out_ready = 1'b0; rd_req = 1'b1;
      for (int j = 0; j < 7; j++) begin
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_chan",  int'(out_chan),  1);
         chk("bp_count", int'(out_count), 0);
         @(negedge clk);
         rd_req = 1'b0;
      end
      chk("bp_hold_chan", int'(out_chan), 1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_next_chan",  int'(out_chan),  2);
      chk("bp_next_count", int'(out_count), MAX);
      @(negedge clk);
      chk("bp_last_chan", int'(out_chan), 3);
      @(negedge clk);
      chk("bp_done", int'(rd_done), 1);
      @(negedge clk);
      chk("bp_idle", int'(busy), 0);
      @(negedge clk);
      chk("bp_no_requeue", int'(out_valid), 0);

      // Snapshot coincides with the 4th channel 0 edge
      do_clear();
      repeat (3) pulse(0);
      y_in[0] = 1'b1;
      repeat (2) @(negedge clk);
      readout(3, 0, 0, 0);
      y_in[0] = 1'b0;
      repeat (3) @(negedge clk);
      readout(4, 0, 0, 0);

      // clear coincides with a channel 1 edge
      y_in[1] = 1'b1;
      repeat (2) @(negedge clk);
      do_clear();
      y_in[1] = 1'b0;
      repeat (3) @(negedge clk);
      readout(0, 0, 0, 0);

      // Reset mid-readout
      repeat (2) pulse(3);
      repeat (2) @(negedge clk);
      rd_req = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_chan", int'(out_chan), 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_busy",  int'(busy),      0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      readout(0, 0, 0, 0);

      // Randomized phase checked by the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) y_in = 4'($urandom_range(0, 15));
         clear     = ($urandom_range(0, 99) == 0);
         rd_req    = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end
      y_in = '0; clear = 1'b0; rd_req = 1'b0; out_ready = 1'b1;
      repeat (10) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
